tx_sched: RTL and testbench
===========================

TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one serial_tx (range 2..16).
REQ-002 The block SHALL have parameter PKT_LENGTH, default 32, giving the packet width, which matches serial_tx.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 16, giving the idle clocks enforced between packets (range 1..65535).
REQ-004 The block SHALL have parameter BUSY_TIMEOUT, default 8, giving the clocks allowed for tx_busy to rise after launch.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req, input, NUM_REQ bits: level request per requester, held until ack.
REQ-008 The block SHALL have port req_data, input, NUM_REQ*PKT_LENGTH bits: packet of requester i in bits [i*PKT_LENGTH +: PKT_LENGTH].
REQ-009 The block SHALL have port ack, output, NUM_REQ bits: one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse on launch timeout.
REQ-011 The block SHALL have port tx_data, output, PKT_LENGTH bits: packet to serial_tx data.
REQ-012 The block SHALL have port tx_new_data, output, 1 bit: launch strobe to serial_tx new_data.
REQ-013 The block SHALL have port tx_busy, input, 1 bit: from serial_tx busy.
REQ-014 The block SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the current or last granted requester.
REQ-015 The block SHALL have port active, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The block SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and GAP, with all outputs registered.
REQ-017 In IDLE with any req bit high, the block SHALL select the winner as the first set req bit at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-018 On that IDLE cycle the block SHALL register the winner's req_data into tx_data and its index into grant_id, then enter LAUNCH.
REQ-019 The block SHALL hold tx_data stable from LAUNCH until the next grant.
REQ-020 In LAUNCH the block SHALL assert tx_new_data for exactly one cycle, then enter WAIT_BUSY with the timeout counter cleared.
REQ-021 In WAIT_BUSY, tx_busy=1 SHALL cause a transition to WAIT_DONE.
REQ-022 In WAIT_BUSY, if BUSY_TIMEOUT cycles elapse without tx_busy, the block SHALL pulse err, leave ack low, keep rr_ptr unchanged, and enter GAP.
REQ-023 In WAIT_DONE, tx_busy=0 SHALL cause the block to pulse ack[grant_id] for one cycle, set rr_ptr to (grant_id+1) mod NUM_REQ, and enter GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES clocks, tracked by a down-counter, and then return to IDLE; tx_new_data SHALL never be asserted outside LAUNCH.
REQ-025 Minimum grant-to-next-grant spacing SHALL be 1 (LAUNCH) + 1 + packet time + GAP_CYCLES + 1 clocks.
REQ-026 A req bit deasserted before selection SHALL be ignored; a req change after grant SHALL not affect the transfer in flight.
REQ-027 When req is all zeros in IDLE, the block SHALL remain in IDLE with no outputs toggling.
REQ-028 With all requesters continuously requesting, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no requester skipped.
REQ-029 A single persistent requester SHALL be re-granted after each GAP without starvation logic interfering.
REQ-030 rr_ptr SHALL wrap from NUM_REQ-1 to 0.
REQ-031 Only requester indices below NUM_REQ SHALL be granted.
REQ-032 Any illegal state encoding SHALL return the block to IDLE on the next clock.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, rr_ptr=0, grant_id=0, tx_data=0, tx_new_data=0, ack=0, err=0, active=0, and clear the gap and timeout counters.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no ack and no err; the first grant after release SHALL use rr_ptr=0.
REQ-035 Deassertion of rst_n SHALL be treated as synchronous to clk by the integrator; the block takes no action until the first clock edge after release.

Verification
REQ-036 Bench SHALL cover: req=4'b0100, data2=32'hA5A5_0F0F with a serial_tx model -> one tx_new_data pulse, tx_data=32'hA5A5_0F0F, grant_id=2, ack=4'b0100 once after busy falls, then GAP_CYCLES idle.
REQ-037 Bench SHALL cover: req=4'b1111 held for 8 packets -> grant_id sequence 0,1,2,3,0,1,2,3, each ack a single cycle.
REQ-038 Bench SHALL cover: tx_busy tied 0 -> err pulse BUSY_TIMEOUT=8 cycles after WAIT_BUSY entry, no ack, same requester re-granted after the gap.
REQ-039 Bench SHALL cover: rst_n pulsed low during WAIT_DONE with grant_id=3 -> all outputs zero immediately; with req=4'b1001 after release, requester 0 is granted first.
REQ-040 Bench SHALL cover: req[1] dropped in the grant cycle, data1 changed during the transfer -> tx_data unchanged and the packet completes with ack[1].
REQ-041 Bench SHALL cover: GAP_CYCLES=1 with back-to-back requests -> exactly one IDLE cycle between the end of GAP and the next LAUNCH, and tx_new_data never overlaps tx_busy=1.

Source files
------------

// File: rtl/tx_sched.sv
// Round-robin scheduler that shares one serial transmitter among NUM_REQ requesters.
// Latency: winner is registered on the cycle after req is seen in IDLE, launch strobe follows from the LAUNCH state.
// Backpressure: req is held until ack; tx_busy paces the transfer; a fixed GAP follows every packet.
module tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int PKT_LENGTH   = 32,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*PKT_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic [PKT_LENGTH-1:0]         tx_data,
  output logic                          tx_new_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TMW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int GPW = 16;

  // Last value of each counter before the state moves on.
  localparam logic [TMW-1:0] TMO_LAST = TMW'(BUSY_TIMEOUT - 1);
  localparam logic [GPW-1:0] GAP_LOAD = GPW'(GAP_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]   NUM_EXT  = (IDW+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t                  state_q;
  logic [IDW-1:0]          rr_q;
  logic [IDW-1:0]          grant_q;
  logic [PKT_LENGTH-1:0]   tx_data_q;
  logic                    tx_new_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic                    err_q;
  logic                    active_q;
  logic [TMW-1:0]          tmo_q;
  logic [GPW-1:0]          gap_q;

  logic                    win_vld_d;
  logic [IDW-1:0]          win_idx_d;
  logic [IDW:0]            cand_d;
  logic [PKT_LENGTH-1:0]   win_dat_d;
  logic [IDW-1:0]          rr_next_d;

  // Round-robin pick: walk downward from the farthest candidate so the one nearest rr_q is kept last.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand_d    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_d = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand_d >= NUM_EXT) begin
        cand_d = cand_d - NUM_EXT;
      end
      if (req[cand_d[IDW-1:0]]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_d[IDW-1:0];
      end
    end
  end

  assign win_dat_d = req_data[win_idx_d*PKT_LENGTH +: PKT_LENGTH];

  // Pointer moves just past the requester that completed, wrapping at the top.
  assign rr_next_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  // Scheduler FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      tx_new_q  <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
    end else begin
      // ack and err are single-cycle pulses.
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            tx_data_q <= win_dat_d;
            grant_q   <= win_idx_d;
            tx_new_q  <= 1'b1;
            active_q  <= 1'b1;
            state_q   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_new_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            // Transmitter never picked the packet up: flag it, leave rr_q so the same requester retries.
            err_q   <= 1'b1;
            gap_q   <= GAP_LOAD;
            state_q <= S_GAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            ack_q[grant_q] <= 1'b1;
            rr_q           <= rr_next_d;
            gap_q          <= GAP_LOAD;
            state_q        <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          tx_new_q <= 1'b0;
          active_q <= 1'b0;
          tmo_q    <= '0;
          gap_q    <= '0;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign tx_data     = tx_data_q;
  assign tx_new_data = tx_new_q;
  assign grant_id    = grant_q;
  assign active      = active_q;

  // Launch strobe only ever accompanies the LAUNCH state.
  a_new_only_launch: assert property (@(posedge clk) disable iff (!rst_n)
    tx_new_data |-> (state_q == S_LAUNCH));

  // At most one requester is acknowledged, and never together with a timeout.
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ack) && !(err && (ack != '0)));

endmodule

// File: tb/tb_tx_sched.sv
module tb_tx_sched;

  localparam int PKT_CLKS = 4;
  localparam logic [31:0] D0 = 32'h1000_0001;
  localparam logic [31:0] D1 = 32'h2000_0002;
  localparam logic [31:0] D2 = 32'hA5A5_0F0F;
  localparam logic [31:0] D3 = 32'h4000_0004;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_v = '0;
  logic         use_g1 = 1'b0;
  logic         bdis = 1'b0;
  logic [127:0] req_data;

  logic [3:0]  req_a, req_b, ack_a, ack_b;
  logic        err_a, err_b, new_a, new_b, busy_a, busy_b, act_a, act_b;
  logic [31:0] dat_a, dat_b;
  logic [1:0]  gid_a, gid_b;
  int          bc_a, bc_b;

  logic [3:0]  m_ack;
  logic        m_err, m_new, m_busy, m_act;
  logic [31:0] m_dat;
  logic [1:0]  m_gid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign req_a = use_g1 ? 4'b0000 : req_v;
  assign req_b = use_g1 ? req_v : 4'b0000;

  tx_sched dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_data(req_data),
    .ack(ack_a), .err(err_a), .tx_data(dat_a), .tx_new_data(new_a),
    .tx_busy(busy_a), .grant_id(gid_a), .active(act_a)
  );

  tx_sched #(.GAP_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(req_data),
    .ack(ack_b), .err(err_b), .tx_data(dat_b), .tx_new_data(new_b),
    .tx_busy(busy_b), .grant_id(gid_b), .active(act_b)
  );

  // serial_tx stand-in: busy rises the clock after new_data and stays up PKT_CLKS cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_a <= 1'b0; bc_a <= 0;
    end else if (bdis) begin
      busy_a <= 1'b0;
    end else if (new_a) begin
      busy_a <= 1'b1; bc_a <= PKT_CLKS - 1;
    end else if (busy_a) begin
      if (bc_a == 0) busy_a <= 1'b0;
      else bc_a <= bc_a - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_b <= 1'b0; bc_b <= 0;
    end else if (bdis) begin
      busy_b <= 1'b0;
    end else if (new_b) begin
      busy_b <= 1'b1; bc_b <= PKT_CLKS - 1;
    end else if (busy_b) begin
      if (bc_b == 0) busy_b <= 1'b0;
      else bc_b <= bc_b - 1;
    end
  end

  assign m_ack  = use_g1 ? ack_b  : ack_a;
  assign m_err  = use_g1 ? err_b  : err_a;
  assign m_new  = use_g1 ? new_b  : new_a;
  assign m_busy = use_g1 ? busy_b : busy_a;
  assign m_act  = use_g1 ? act_b  : act_a;
  assign m_dat  = use_g1 ? dat_b  : dat_a;
  assign m_gid  = use_g1 ? gid_b  : gid_a;

  typedef struct {
    bit         g1;
    logic [3:0] req;
    bit         bdis;
    bit         mut;
    int         gid;
    logic [31:0] dat;
    logic [3:0] ack;
    int         ackcnt;
    int         errcnt;
    int         endoff;
    int         gap;
  } vec_t;

  typedef struct {
    int          wait_c;
    int          stray;
    int          launch;
    int          gid;
    logic [31:0] dat;
    logic [3:0]  ack;
    int          ackcnt;
    int          errcnt;
    int          endoff;
    int          gap;
    int          unstable;
    int          overlap;
    bit          tmo;
  } obs_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observe one packet from launch to the return to IDLE, sampling on falling edges.
  task automatic run_txn(input bit mut, output obs_t o);
    int  t;
    bit  seen;
    o = '{default: 0};
    t = 0;
    while (t < 100) begin
      if (m_new === 1'b1) break;
      if (m_ack != 4'b0000 || m_err) o.stray++;
      @(negedge clk);
      t++;
    end
    o.wait_c = t;
    if (m_new !== 1'b1) begin
      o.tmo = 1'b1;
      return;
    end
    o.launch = 1;
    o.gid    = int'(m_gid);
    o.dat    = m_dat;
    if (m_busy) o.overlap++;
    if (mut) begin
      req_v = 4'b0000;
      req_data[32 +: 32] = 32'hDEAD_BEEF;
    end
    seen = 1'b0;
    t = 0;
    while (t < 400) begin
      @(negedge clk);
      t++;
      if (!m_act) break;
      if (m_new) o.launch++;
      if (m_new && m_busy) o.overlap++;
      if (m_dat !== o.dat) o.unstable++;
      if (m_ack != 4'b0000) begin
        o.ackcnt++;
        o.ack = o.ack | m_ack;
      end
      if (m_err) o.errcnt++;
      if ((m_ack != 4'b0000 || m_err) && !seen) begin
        seen = 1'b1;
        o.endoff = t;
      end
      if (seen) o.gap++;
    end
    if (m_act) o.tmo = 1'b1;
    if (mut) req_data[32 +: 32] = D1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t o;
    vec_t v;
    int   chg;
    logic [41:0] snap;

    req_data = {D3, D2, D1, D0};

    //             g1 req     bd mut gid dat ack     ac ec off gap
    vq.push_back('{0, 4'b1111, 0, 0, 0, D0, 4'b0001, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1111, 0, 0, 1, D1, 4'b0010, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1111, 0, 0, 2, D2, 4'b0100, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1111, 0, 0, 3, D3, 4'b1000, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1111, 0, 0, 0, D0, 4'b0001, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1111, 0, 0, 1, D1, 4'b0010, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1111, 0, 0, 2, D2, 4'b0100, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1111, 0, 0, 3, D3, 4'b1000, 1, 0, 6, 16});
    vq.push_back('{0, 4'b0100, 0, 0, 2, D2, 4'b0100, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1001, 1, 0, 3, D3, 4'b0000, 0, 1, 9, 16});
    vq.push_back('{0, 4'b1001, 0, 0, 3, D3, 4'b1000, 1, 0, 6, 16});
    vq.push_back('{0, 4'b1001, 0, 0, 0, D0, 4'b0001, 1, 0, 6, 16});
    vq.push_back('{0, 4'b0001, 0, 0, 0, D0, 4'b0001, 1, 0, 6, 16});
    vq.push_back('{0, 4'b0110, 0, 0, 1, D1, 4'b0010, 1, 0, 6, 16});
    vq.push_back('{0, 4'b0011, 0, 0, 0, D0, 4'b0001, 1, 0, 6, 16});
    vq.push_back('{0, 4'b0010, 0, 1, 1, D1, 4'b0010, 1, 0, 6, 16});
    vq.push_back('{1, 4'b1111, 0, 0, 0, D0, 4'b0001, 1, 0, 6, 1});
    vq.push_back('{1, 4'b1111, 0, 0, 1, D1, 4'b0010, 1, 0, 6, 1});
    vq.push_back('{1, 4'b1111, 0, 0, 2, D2, 4'b0100, 1, 0, 6, 1});
    vq.push_back('{1, 4'b1111, 0, 0, 3, D3, 4'b1000, 1, 0, 6, 1});
    vq.push_back('{1, 4'b1111, 0, 0, 0, D0, 4'b0001, 1, 0, 6, 1});

    // reset held with requests pending: nothing may launch
    req_v = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst ack", ack_a, 4'b0000);
    chk("rst err", err_a, 1'b0);
    chk("rst tx_data", dat_a, 32'h0);
    chk("rst tx_new_data", new_a, 1'b0);
    chk("rst grant_id", gid_a, 2'd0);
    chk("rst active", act_a, 1'b0);

    // no requests: outputs stay frozen
    req_v = 4'b0000;
    rst_n = 1'b1;
    snap = {ack_a, err_a, dat_a, new_a, gid_a, act_a};
    chg = 0;
    repeat (20) begin
      @(negedge clk);
      if ({ack_a, err_a, dat_a, new_a, gid_a, act_a} !== snap) chg++;
    end
    chk("idle output changes", chg, 0);
    chk("idle active", act_a, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      use_g1 = v.g1;
      bdis   = v.bdis;
      req_v  = v.req;
      run_txn(v.mut, o);
      chk($sformatf("v%0d timeout", i), o.tmo, 1'b0);
      chk($sformatf("v%0d idle cycles", i), o.wait_c, 1);
      chk($sformatf("v%0d stray pulse", i), o.stray, 0);
      chk($sformatf("v%0d launches", i), o.launch, 1);
      chk($sformatf("v%0d grant_id", i), o.gid, v.gid);
      chk($sformatf("v%0d tx_data", i), o.dat, v.dat);
      chk($sformatf("v%0d tx_data stable", i), o.unstable, 0);
      chk($sformatf("v%0d ack", i), o.ack, v.ack);
      chk($sformatf("v%0d ack cycles", i), o.ackcnt, v.ackcnt);
      chk($sformatf("v%0d err cycles", i), o.errcnt, v.errcnt);
      chk($sformatf("v%0d end offset", i), o.endoff, v.endoff);
      chk($sformatf("v%0d gap", i), o.gap, v.gap);
      chk($sformatf("v%0d new/busy overlap", i), o.overlap, 0);
    end

    // reset in WAIT_DONE with requester 3 granted
    use_g1 = 1'b0;
    bdis   = 1'b0;
    req_v  = 4'b1000;
    begin
      int t;
      t = 0;
      while (new_a !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    chk("mid launch seen", new_a, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("mid grant_id", gid_a, 2'd3);
    chk("mid active", act_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid rst ack", ack_a, 4'b0000);
    chk("mid rst err", err_a, 1'b0);
    chk("mid rst tx_data", dat_a, 32'h0);
    chk("mid rst tx_new_data", new_a, 1'b0);
    chk("mid rst grant_id", gid_a, 2'd0);
    chk("mid rst active", act_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    req_v = 4'b1001;
    rst_n = 1'b1;
    run_txn(1'b0, o);
    chk("post rst timeout", o.tmo, 1'b0);
    chk("post rst stray pulse", o.stray, 0);
    chk("post rst grant_id", o.gid, 0);
    chk("post rst tx_data", o.dat, D0);
    chk("post rst ack", o.ack, 4'b0001);
    chk("post rst err cycles", o.errcnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
